// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
//   Turns the raw PS/2 set-2 scan-code byte stream into complete key events
//   (code, extended, break), queues them in a show-ahead FIFO with a
//   valid/ready handshake, and tracks held state for the game keys.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   byte_in    received scan-code byte (valid while byte_valid is high)
//   byte_valid one-cycle strobe from the PS/2 byte receiver
//   evt_code   head-of-FIFO scan code, prefixes stripped
//   evt_ext    head event carried the E0 prefix
//   evt_break  head event is a release (carried F0)
//   evt_valid  FIFO not empty
//   evt_ready  consumer takes the head event this cycle
//   key_left   left arrow (E0 6B) held
//   key_right  right arrow (E0 74) held
//   key_jump   space (29) or up arrow (E0 75) held
//   overflow   sticky: an event was dropped because the FIFO was full
//
// Optional build macro
//   PS2_TYPEMATIC_FILTER_EN  suppress auto-repeat makes of the last key pressed

module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       key_left,
    output logic       key_right,
    output logic       key_jump,
    output logic       overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]      CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t            state, next_state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              emit, emit_ext, emit_brk;
    logic              suppress, push;

    // Bytes that carry no key information when seen outside a prefix
    // (ACK, BAT result, resend, echo, errors, Pause prefix).
    function automatic logic is_noise(input logic [7:0] b);
        case (b)
            8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_noise = 1'b1;
            default:                                        is_noise = 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (byte_in == 8'hE0) begin
                        next_state = GOT_E0;
                    end else if (byte_in == 8'hF0) begin
                        next_state = GOT_F0;
                    end else if (!is_noise(byte_in)) begin
                        emit = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (byte_in == 8'hF0) begin
                        next_state = GOT_E0F0;
                    end else if (byte_in != 8'hE0) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        next_state = IDLE;
                    end
                end
                GOT_F0: begin
                    if (byte_in == 8'hE0) begin
                        next_state = GOT_E0F0;
                    end else if (byte_in != 8'hF0) begin
                        emit       = 1'b1;
                        emit_brk   = 1'b1;
                        next_state = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (byte_in != 8'hE0 && byte_in != 8'hF0) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        emit_brk   = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
            // Prefix went stale (lost byte); abandon it silently.
            next_state = IDLE;
        end
    end

    // Idle-cycle counter, only meaningful while a prefix is pending.
    always_ff @(posedge clk) begin
        if (rst || byte_valid || state == IDLE || tmo_cnt == TMO_LAST) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Typematic (auto-repeat) filter
    // ------------------------------------------------------------------
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0] rep_code;
    logic       rep_ext;
    logic       rep_vld;
    logic       rep_match;

    assign rep_match = rep_vld && rep_code == byte_in && rep_ext == emit_ext;
    assign suppress  = emit && !emit_brk && rep_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_code <= 8'h00;
            rep_ext  <= 1'b0;
            rep_vld  <= 1'b0;
        end else if (emit && !suppress) begin
            if (!emit_brk) begin
                rep_code <= byte_in;
                rep_ext  <= emit_ext;
                rep_vld  <= 1'b1;
            end else if (rep_match) begin
                rep_vld  <= 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign push = emit && !suppress;

    // ------------------------------------------------------------------
    // Held-key flags: follow every accepted event, even if the FIFO drops it
    // ------------------------------------------------------------------
    logic left_held, right_held, space_held, up_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            left_held  <= 1'b0;
            right_held <= 1'b0;
            space_held <= 1'b0;
            up_held    <= 1'b0;
        end else if (push) begin
            case ({emit_ext, byte_in})
                9'h16B:  left_held  <= !emit_brk;
                9'h174:  right_held <= !emit_brk;
                9'h029:  space_held <= !emit_brk;
                9'h175:  up_held    <= !emit_brk;
                default: ;
            endcase
        end
    end

    assign key_left  = left_held;
    assign key_right = right_held;
    assign key_jump  = space_held | up_held;

    // ------------------------------------------------------------------
    // Event FIFO: entries are {code, ext, brk}
    // ------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0][9:0] mem;
    logic [AW-1:0]              wr_ptr, rd_ptr, rd_ptr_next;
    logic [AW:0]                count;
    logic                       full, pop, wr_en;
    logic [9:0]                 new_entry, head, head_next;
    logic [AW:0]                count_next;

    assign new_entry = {byte_in, emit_ext, emit_brk};
    assign full      = (count == CNT_FULL);
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign wr_en     = push && (!full || pop);

    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_next = count;
        if (wr_en && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !wr_en) begin
            count_next = count - 1'b1;
        end
    end

    // Head is a register so it can hold its last value once the FIFO drains.
    // When the next head slot is the one being written this cycle, bypass
    // the memory and take the incoming event.
    always_comb begin
        head_next = head;
        if (count_next != '0) begin
            if (wr_en && rd_ptr_next == wr_ptr) begin
                head_next = new_entry;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            head   <= head_next;
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    assign evt_code  = head[9:2];
    assign evt_ext   = head[1];
    assign evt_break = head[0];

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer. Inputs change on the falling edge;
// outputs are sampled on the falling edge after the rising edge under test.

module tb_ps2_key_sequencer;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext, evt_break, evt_valid;
    logic       evt_ready = 1'b0;
    logic       key_left, key_right, key_jump, overflow;

    int checks   = 0;
    int failures = 0;

    ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Check head event {code, ext, brk} then pop it with a one-cycle ready.
    task automatic pop_check(input string tag, input logic [7:0] c, input logic e, input logic b);
        check({tag, "_vld"}, {31'd0, evt_valid}, 32'd1);
        check({tag, "_evt"}, {22'd0, evt_code, evt_ext, evt_break}, {22'd0, c, e, b});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        // Reset state after some prior activity
        send(8'h1C);
        do_reset();
        check("rst_vld", {31'd0, evt_valid}, 32'd0);
        check("rst_code", {24'd0, evt_code}, 32'h00);
        check("rst_flags", {27'd0, evt_ext, evt_break, key_left, key_right, key_jump}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // Single make, one-cycle latency, pop empties
        send(8'h1C);
        pop_check("mk1c", 8'h1C, 1'b0, 1'b0);
        check("mk1c_empty", {31'd0, evt_valid}, 32'd0);
        check("mk1c_hold", {24'd0, evt_code}, 32'h1C);
        evt_ready = 1'b1;  // ready while empty is harmless
        idle(2);
        evt_ready = 1'b0;
        check("rdy_empty", {31'd0, evt_valid}, 32'd0);

        // Noise bytes in IDLE are discarded
        send(8'hAA); send(8'hFA); send(8'h00);
        check("noise", {31'd0, evt_valid}, 32'd0);

        // Left arrow make/break with ready held high
        evt_ready = 1'b1;
        send(8'hE0);
        check("left_pre", {31'd0, key_left}, 32'd0);
        send(8'h6B);
        check("left_mk_evt", {22'd0, evt_valid, evt_code, evt_ext, evt_break}, {22'd0, 1'b1, 8'h6B, 2'b10});
        check("left_mk_key", {31'd0, key_left}, 32'd1);
        send(8'hE0); send(8'hF0);
        check("left_mid", {31'd0, key_left}, 32'd1);
        send(8'h6B);
        check("left_br_evt", {22'd0, evt_valid, evt_code, evt_ext, evt_break}, {22'd0, 1'b1, 8'h6B, 2'b11});
        check("left_br_key", {31'd0, key_left}, 32'd0);
        idle(1);
        check("left_drain", {31'd0, evt_valid}, 32'd0);
        evt_ready = 1'b0;

        // Right / up arrows, F0-then-E0 ordering
        send(8'hE0); send(8'h74);
        send(8'hE0); send(8'h75);
        check("right_up", {30'd0, key_right, key_jump}, 32'd3);
        send(8'hF0); send(8'hE0); send(8'h74);
        check("right_off", {30'd0, key_right, key_jump}, 32'd1);
        pop_check("ru1", 8'h74, 1'b1, 1'b0);
        pop_check("ru2", 8'h75, 1'b1, 1'b0);
        pop_check("ru3", 8'h74, 1'b1, 1'b1);

        // Timeout abandons E0; short gap keeps it
        do_reset();
        send(8'hE0);
        idle(TO + 4);
        send(8'h29);
        check("to_jump", {31'd0, key_jump}, 32'd1);
        pop_check("to_evt", 8'h29, 1'b0, 1'b0);
        check("to_single", {31'd0, evt_valid}, 32'd0);
        send(8'hE0);
        idle(3);
        send(8'h6B);
        pop_check("to_short", 8'h6B, 1'b1, 1'b0);

        // Reset mid-prefix discards it
        send(8'hE0);
        do_reset();
        send(8'h1C);
        pop_check("rst_mid", 8'h1C, 1'b0, 1'b0);

        // Overflow: 5 makes into a 4-deep FIFO
        do_reset();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        pop_check("ovf0", 8'h15, 1'b0, 1'b0);
        pop_check("ovf1", 8'h1D, 1'b0, 1'b0);
        pop_check("ovf2", 8'h24, 1'b0, 1'b0);
        pop_check("ovf3", 8'h2D, 1'b0, 1'b0);
        check("ovf_empty", {31'd0, evt_valid}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_reset();
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // Push and pop together while full
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        @(negedge clk);
        byte_in = 8'h33; byte_valid = 1'b1; evt_ready = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; evt_ready = 1'b0;
        check("fp_ovf", {31'd0, overflow}, 32'd0);
        pop_check("fp0", 8'h1D, 1'b0, 1'b0);
        pop_check("fp1", 8'h24, 1'b0, 1'b0);
        pop_check("fp2", 8'h2D, 1'b0, 1'b0);
        pop_check("fp3", 8'h33, 1'b0, 1'b0);
        check("fp_empty", {31'd0, evt_valid}, 32'd0);

        // Push and pop together with one entry: new event becomes head
        send(8'h1C);
        @(negedge clk);
        byte_in = 8'h32; byte_valid = 1'b1; evt_ready = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; evt_ready = 1'b0;
        pop_check("one_pp", 8'h32, 1'b0, 1'b0);
        check("one_empty", {31'd0, evt_valid}, 32'd0);

        // Auto-repeat stream
        do_reset();
        send(8'h29); send(8'h29); send(8'h29); send(8'hF0); send(8'h29);
        check("rep_jump", {31'd0, key_jump}, 32'd0);
`ifdef PS2_TYPEMATIC_FILTER_EN
        pop_check("rep0", 8'h29, 1'b0, 1'b0);
        pop_check("rep1", 8'h29, 1'b0, 1'b1);
`else
        pop_check("rep0", 8'h29, 1'b0, 1'b0);
        pop_check("rep1", 8'h29, 1'b0, 1'b0);
        pop_check("rep2", 8'h29, 1'b0, 1'b0);
        pop_check("rep3", 8'h29, 1'b0, 1'b1);
`endif
        check("rep_empty", {31'd0, evt_valid}, 32'd0);
        check("rep_ovf", {31'd0, overflow}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
